// File: rtl/arb_oht_if.sv
// rtl/arb_oht_if.sv - request/grant handshake bundle between arb_oht and its grant consumer.
interface arb_oht_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] req;
  logic             gnt_vld;
  logic             gnt_rdy;
  logic [WIDTH-1:0] gnt;

  modport master (
    input  req,
    input  gnt_rdy,
    output gnt_vld,
    output gnt
  );

  modport slave (
    output req,
    output gnt_rdy,
    input  gnt_vld,
    input  gnt
  );
endinterface

// File: rtl/arb_oht.sv
// rtl/arb_oht.sv - registered one-hot request arbiter with valid/ready grant handshake.
// Fixed priority by default; define ARB_OHT_ROUND_ROBIN_EN for round-robin arbitration.
module arb_oht #(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic     clk,
  input  logic     rst,
  arb_oht_if.master bus
);
  localparam int PW  = $clog2(WIDTH);
  localparam int NG  = (WIDTH + SPLIT - 1) / SPLIT;
  localparam int PAD = NG * SPLIT;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [WIDTH-1:0] gnt_q;
  logic             vld_q;
  logic [WIDTH-1:0] sel;
  logic             xfer;

  // Lowest-set-bit to one-hot: radix-SPLIT tree (groups, then group select) or flat carry form.
  function automatic logic [WIDTH-1:0] pick_low(input logic [WIDTH-1:0] v);
    logic [PAD-1:0]   vp;
    logic [PAD-1:0]   loc;
    logic [PAD-1:0]   res;
    logic [NG-1:0]    grp_any;
    logic [NG-1:0]    grp_sel;
    logic [SPLIT-1:0] grp;
    if (IMPLEMENTATION == 0) begin
      vp = PAD'(v);
      for (int g = 0; g < NG; g++) begin
        grp                    = vp[g*SPLIT +: SPLIT];
        grp_any[g]             = |grp;
        loc[g*SPLIT +: SPLIT]  = grp & (~grp + SPLIT'(1));
      end
      grp_sel = grp_any & (~grp_any + NG'(1));
      for (int g = 0; g < NG; g++) begin
        res[g*SPLIT +: SPLIT] = grp_sel[g] ? loc[g*SPLIT +: SPLIT] : '0;
      end
      return res[WIDTH-1:0];
    end else begin
      return v & (~v + WIDTH'(1));
    end
  endfunction

  assign xfer = vld_q & bus.gnt_rdy;

`ifdef ARB_OHT_ROUND_ROBIN_EN
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    sel_ptr;
  logic [WIDTH-1:0] masked;

  // On a back-to-back transfer the grant being accepted becomes the priority pointer.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gnt_q[i]) gnt_idx = gnt_idx | PW'(i);
    end
    sel_ptr = xfer ? gnt_idx : ptr;
    masked  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      masked[i] = bus.req[i] && (PW'(i) > sel_ptr);
    end
    sel = (|masked) ? pick_low(masked) : pick_low(bus.req);
  end
`else
  always_comb begin
    sel = pick_low(bus.req);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
      vld_q <= 1'b0;
`ifdef ARB_OHT_ROUND_ROBIN_EN
      ptr   <= PW'(WIDTH - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt_q <= sel;
            vld_q <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (bus.gnt_rdy) begin
`ifdef ARB_OHT_ROUND_ROBIN_EN
            ptr <= gnt_idx;
`endif
            if (|bus.req) begin
              gnt_q <= sel;
            end else begin
              gnt_q <= '0;
              vld_q <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          gnt_q <= '0;
          vld_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = vld_q;
endmodule

// File: tb/tb_arb_oht.sv
// tb/tb_arb_oht.sv - directed and random checks of arb_oht against an index-scanning reference model.
module tb_arb_oht;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  int   m_vld = 0;
  int   m_idx = -1;
  int   m_ptr = W - 1;

  arb_oht_if #(.WIDTH(W)) bus ();

  arb_oht #(.WIDTH(W), .SPLIT(4), .IMPLEMENTATION(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Winner = first requester found scanning upward from just past the last transferred index.
  function automatic int pick(input logic [W-1:0] r, input int last);
    int j;
`ifdef ARB_OHT_ROUND_ROBIN_EN
    for (int k = 1; k <= W; k++) begin
      j = (last + k) % W;
      if (r[j]) return j;
    end
`else
    for (j = 0; j < W; j++) begin
      if (r[j]) return j;
    end
`endif
    return -1;
  endfunction

  function automatic int oht2bin(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) n = n + i;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [W-1:0] rq, input logic rdy);
    logic [W-1:0] exp_gnt;
    rst         = r;
    bus.req     = rq;
    bus.gnt_rdy = rdy;
    @(posedge clk);
    if (r) begin
      m_vld = 0;
      m_idx = -1;
      m_ptr = W - 1;
    end else if (m_vld == 0) begin
      if (rq != '0) begin
        m_idx = pick(rq, m_ptr);
        m_vld = 1;
      end
    end else if (rdy) begin
      m_ptr = m_idx;
      if (rq != '0) begin
        m_idx = pick(rq, m_ptr);
      end else begin
        m_vld = 0;
        m_idx = -1;
      end
    end
    #1;
    exp_gnt = (m_vld != 0) ? (W'(1) << m_idx) : '0;
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
    chk("gnt_vld", 32'(bus.gnt_vld), 32'(m_vld != 0));
    chk("onehot0", 32'($countones(bus.gnt) <= 1), 32'(1));
    chk("vld_eq_or_gnt", 32'(bus.gnt_vld), 32'(|bus.gnt));
    if (m_vld != 0) chk("oht2bin", 32'(oht2bin(bus.gnt)), 32'(m_idx));
  endtask

  initial begin
    logic [W-1:0] rq;

    // 1: reset with all requesting, then index 0 first
    cycle(1'b1, 16'hFFFF, 1'b0);
    chk("t1_rst_vld", 32'(bus.gnt_vld), 32'(0));
    cycle(1'b1, 16'hFFFF, 1'b0);
    chk("t1_rst_gnt", 32'(bus.gnt), 32'(0));
    cycle(1'b0, 16'hFFFF, 1'b0);
    chk("t1_first", 32'(bus.gnt), 32'h0001);

    // 2: hold while consumer stalls, even as req changes
    cycle(1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0010, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0001, 1'b0);
    chk("t2_hold", 32'(bus.gnt), 32'h0010);
    cycle(1'b0, 16'h0001, 1'b1);
    chk("t2_next", 32'(bus.gnt), 32'h0001);

    // 3: back-to-back
    cycle(1'b1, 16'h0000, 1'b0);
    cycle(1'b0, 16'h8001, 1'b1);
    chk("t3_b2b0", 32'(bus.gnt), 32'h0001);
    cycle(1'b0, 16'h8001, 1'b1);
`ifdef ARB_OHT_ROUND_ROBIN_EN
    chk("t3_b2b1", 32'(bus.gnt), 32'h8000);
`else
    chk("t3_b2b1", 32'(bus.gnt), 32'h0001);
`endif
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h8001, 1'b1);

    // 4: wrap-around then drain to idle
    cycle(1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0006, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("t4_idle", 32'(bus.gnt_vld), 32'(0));

    // 5: requester withdraws while grant pending
    cycle(1'b1, 16'h0000, 1'b0);
    cycle(1'b0, 16'h0100, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0);
    chk("t5_pending", 32'(bus.gnt), 32'h0100);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("t5_idle", 32'(bus.gnt_vld), 32'(0));
    cycle(1'b0, 16'h0000, 1'b1);

    // 6: reset mid-grant after a transfer moved the pointer
    cycle(1'b1, 16'h0000, 1'b0);
    cycle(1'b0, 16'h0040, 1'b0);
    cycle(1'b0, 16'h0040, 1'b1);
    cycle(1'b0, 16'h0040, 1'b0);
    cycle(1'b1, 16'h0040, 1'b1);
    chk("t6_rst_gnt", 32'(bus.gnt), 32'(0));
    cycle(1'b0, 16'hFFFF, 1'b0);
    chk("t6_ptr_reset", 32'(bus.gnt), 32'h0001);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: rq = '0;
        1: rq = W'(1) << $urandom_range(0, W - 1);
        2: rq = W'($urandom);
        default: rq = W'($urandom & $urandom);
      endcase
      cycle($urandom_range(0, 49) == 0, rq, $urandom_range(0, 2) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
